// File: rtl/ice51_pkg.sv
// Shared definitions for the ice51 boot path: UART timing, code-memory size
// and the receive/load FSM state encoding.
package ice51_pkg;

  localparam int UART_CLKS_PER_BIT = 104;  // 12 MHz / 115200 baud
  localparam int CODE_MEM_SIZE     = 512;

  // state      | meaning
  // ST_IDLE    | line idle, waiting for a falling edge
  // ST_START   | timing to mid start bit to reject glitches
  // ST_DATA    | sampling 8 data bits mid-bit, LSB first
  // ST_STOP    | sampling the stop bit
  // ST_WAIT_HI | after a framing error, wait for the line to return high
  // ST_DONE    | image complete, line activity ignored
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/ice51_uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser plus the frame FSM.
// Emits a one-cycle byte-valid pulse or a one-cycle frame-error pulse.
//
// state      | meaning
// ST_IDLE    | waiting for rxs to go low
// ST_START   | half a bit in; high again means a false start
// ST_DATA    | one sample every bit period, LSB first
// ST_STOP    | stop bit sample decides valid vs framing error
// ST_WAIT_HI | hold off until the line is released (break protection)
module ice51_uart_rx
  import ice51_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_uart_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  logic          r_rx_meta;
  logic          r_rxs;
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic          r_frame_err;

  // Synchronise the asynchronous line; reset to idle-high so no false start.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // Frame FSM with an up-counting bit timer.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer   <= '0;
          r_bit_idx <= '0;
          if (!r_rxs) r_state <= ST_START;
        end
        ST_START: begin
          if (r_timer == T_HALF) begin
            r_timer <= '0;
            r_state <= r_rxs ? ST_IDLE : ST_DATA;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_DATA: begin
          if (r_timer == T_FULL) begin
            r_timer   <= '0;
            r_shift   <= {r_rxs, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= ST_STOP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_STOP: begin
          if (r_timer == T_FULL) begin
            r_timer <= '0;
            if (r_rxs) begin
              r_valid <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HI;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_WAIT_HI: begin
          if (r_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_shift;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ice51_uart_loader.sv
// Boot loader: streams received UART bytes into code memory from address 0,
// then raises a sticky boot-done that releases the core. PRELOAD bypasses
// loading entirely.
module ice51_uart_loader
  import ice51_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int MEM_SIZE     = CODE_MEM_SIZE,
  parameter int ADDR_W       = 9,
  parameter int PRELOAD      = 0
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_uart_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data,
  output logic              o_boot_done,
  output logic              o_frame_err
);

  localparam int CW = ADDR_W + 1;
  // Count value once the last byte has been written; CW bits avoid wrap.
  localparam logic [CW-1:0] CNT_FULL = CW'(MEM_SIZE);

  logic              w_rx_valid;
  logic [7:0]        w_rx_data;
  logic              w_rx_frame_err;

  logic [CW-1:0]     r_count;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_done;
  logic              r_frame_err;

  ice51_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_uart_rx   (i_uart_rx),
    .o_valid     (w_rx_valid),
    .o_data      (w_rx_data),
    .o_frame_err (w_rx_frame_err)
  );

  // Write sequencing; done follows the final strobe by one cycle and is sticky.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_count     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_frame_err <= 1'b0;
      if (PRELOAD != 0) begin
        r_done <= 1'b1;
      end else if (!r_done) begin
        if (r_mem_we && r_count == CNT_FULL) begin
          r_done <= 1'b1;
        end else if (w_rx_valid) begin
          r_mem_we   <= 1'b1;
          r_mem_addr <= r_count[ADDR_W-1:0];
          r_mem_data <= w_rx_data;
          r_count    <= r_count + CW'(1);
        end else if (w_rx_frame_err) begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = r_mem_data;
  assign o_boot_done = r_done;
  assign o_frame_err = r_frame_err;

endmodule

// File: doc/ice51_uart_loader.md
Name: ice51_uart_loader

Overview:
Boot-stage block upstream of the ice51 core.
- Deserialises 8N1 UART bytes from the host pin.
- Writes them sequentially into code memory from address 0 up to MEM_SIZE-1.
- Asserts a sticky boot-done flag that releases the core from hold once the image is complete.
- With PRELOAD=1 it skips loading and releases the core immediately.

Parameters:
CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200).
MEM_SIZE, 512, number of bytes loaded before boot-done.
ADDR_W, 9, code-memory address width; must satisfy 2**ADDR_W >= MEM_SIZE.
PRELOAD, 0, 1 = no UART load; boot-done asserts right after reset.

Ports:
i_clk  in  1  system clock; all logic on the rising edge
i_nrst  in  1  reset, synchronous, active-low
i_uart_rx  in  1  asynchronous UART line, idle high
o_mem_we  out  1  one-cycle code-memory write strobe
o_mem_addr  out  ADDR_W  write address
o_mem_data  out  8  write data
o_boot_done  out  1  image loaded; core may run; sticky until reset
o_frame_err  out  1  one-cycle pulse on a bad stop bit

Behaviour:
Clocking and reset
- One clock domain, i_clk.
- Reset is synchronous and active-low on i_nrst.
- Reset values: o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_boot_done=0, o_frame_err=0, FSM=IDLE, byte count=0, both synchroniser flops=1.
- Reset mid-byte or mid-image aborts everything; loading restarts at address 0.

Input synchroniser
- i_uart_rx passes through 2 flops; all decisions use the synchronised value `rxs`.

FSM: IDLE, START, DATA, STOP, WAIT_HI, DONE
- IDLE: rxs==0 → START; bit timer cleared.
- START: at timer == CLKS_PER_BIT/2-1 (mid start bit):
  - rxs==1 → false start, return to IDLE, no strobe;
  - rxs==0 → DATA, timer cleared.
- DATA: sample rxs every CLKS_PER_BIT cycles (mid-bit); shift in LSB first. After 8 samples → STOP.
- STOP: after CLKS_PER_BIT cycles, sample rxs.
  - rxs==1: byte is valid. Next cycle: o_mem_we=1, o_mem_addr=count, o_mem_data=byte. count+1. FSM → IDLE, or → DONE if count was MEM_SIZE-1.
  - rxs==0: framing error. Next cycle: o_frame_err=1, no write, count unchanged. FSM → WAIT_HI.
- WAIT_HI: hold until rxs==1 → IDLE. This prevents a break condition being taken as a start bit.
- DONE: o_boot_done=1. Further line activity is ignored: no o_mem_we, no o_frame_err.

Output behaviour
- o_mem_addr/o_mem_data hold their last values between strobes.
- o_mem_we is never high on two consecutive cycles.
- o_boot_done rises in the cycle after the final write strobe.
- PRELOAD=1: FSM goes straight to DONE. o_boot_done=1 in the first cycle after i_nrst is sampled high. No writes ever.

Widths
- Bit timer: clog2(CLKS_PER_BIT) bits.
- Bit index: 3 bits.
- Byte count: ADDR_W+1 bits; compared against MEM_SIZE-1 without wrap.

Decomposition:
- Shared package ice51_pkg:
  - state enum for the FSM above;
  - constants UART_CLKS_PER_BIT=104 and CODE_MEM_SIZE=512, also used by ice51_top and the UART TX.
- One natural sub-module, ice51_uart_rx: synchroniser + START/DATA/STOP/WAIT_HI.
  - Outputs: byte-valid pulse, data, frame-error pulse.
  - Reusable by the core's serial peripheral.
- The loader wrapper holds the address counter, DONE and PRELOAD.

Test Plan:
- MEM_SIZE=4; send 0xA5,0x3C,0xFF,0x00 at 8681 ns/bit → four o_mem_we pulses: addr 0..3, data A5,3C,FF,00. o_boot_done rises the cycle after the 4th strobe.
- After done, send 0x55 → no o_mem_we, no o_frame_err; o_boot_done stays 1.
- Send a 0x12 frame with stop bit driven 0, then line high, then 0x34 → o_frame_err pulses once; next write is addr 0, data 0x34.
- Glitch: rx low for 20 cycles then high → no strobe, FSM back in IDLE. A following 0x77 writes addr 0.
- Pull i_nrst low for 2 cycles during data bit 4 of byte 2 → all outputs at reset values. Re-sent image starts at addr 0.
- PRELOAD=1 → o_boot_done=1 one cycle after reset release; UART traffic produces no writes.
